// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache between the CPU
// load/store path and a block-wide data memory with a busy handshake.
//   CLK, RESET          clock (posedge) and asynchronous active-high reset
//   read, write         CPU load/store request (both high = store)
//   address, writedata  CPU word address and store data
//   readdata            load data: combinational on a read hit, held otherwise
//   busy                stall; CPU must hold its request while high
//   mem_read/mem_write  block refill / victim writeback request
//   mem_addr            block address {tag,index}
//   mem_writedata       victim block, word 0 in LSBs
//   mem_readdata        refill block, word 0 in LSBs
//   mem_busy            memory transfer in progress
module data_cache #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned NUM_LINES      = 8,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic                               read,
    input  logic                               write,
    input  logic [ADDR_W-1:0]                  address,
    input  logic [DATA_W-1:0]                  writedata,
    output logic [DATA_W-1:0]                  readdata,
    output logic                               busy,
    output logic                               mem_read,
    output logic                               mem_write,
    output logic [ADDR_W-$clog2(WORDS_PER_LINE)-1:0] mem_addr,
    output logic [DATA_W*WORDS_PER_LINE-1:0]   mem_writedata,
    input  logic [DATA_W*WORDS_PER_LINE-1:0]   mem_readdata,
    input  logic                               mem_busy
);
    localparam int unsigned OFF = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX = $clog2(NUM_LINES);
    localparam int unsigned TAG = ADDR_W - IDX - OFF;

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate, StUpdate} state_e;

    state_e                r_state, w_state_d;
    logic [NUM_LINES-1:0]  r_valid, r_dirty;
    logic [TAG-1:0]        r_tag  [NUM_LINES];
    logic [DATA_W-1:0]     r_data [NUM_LINES][WORDS_PER_LINE];
    logic [DATA_W-1:0]     r_readdata;

    logic [OFF-1:0]        w_off;
    logic [IDX-1:0]        w_idx;
    logic [TAG-1:0]        w_tag;
    logic                  w_request, w_hit, w_rd_hit, w_wr_hit;
    logic [DATA_W-1:0]     w_word;

    assign w_off     = address[OFF-1:0];
    assign w_idx     = address[OFF +: IDX];
    assign w_tag     = address[ADDR_W-1 -: TAG];
    assign w_request = read | write;
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_word    = r_data[w_idx][w_off];
    assign w_rd_hit  = (r_state == StIdle) && read && !write && w_hit;
    assign w_wr_hit  = (r_state == StIdle) && write && w_hit;

    always_comb begin
        w_state_d     = r_state;
        busy          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = {w_tag, w_idx};
        mem_writedata = '0;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            mem_writedata[w*DATA_W +: DATA_W] = r_data[w_idx][w];
        end
        unique case (r_state)
            StIdle: begin
                // Miss raises busy in the same cycle the request is seen.
                if (w_request && !w_hit) begin
                    busy      = 1'b1;
                    w_state_d = (r_valid[w_idx] && r_dirty[w_idx]) ? StWriteback : StAllocate;
                end
            end
            StWriteback: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = {r_tag[w_idx], w_idx};
                if (!mem_busy) w_state_d = StAllocate;
            end
            StAllocate: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (!mem_busy) w_state_d = StUpdate;
            end
            StUpdate: begin
                busy      = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
        // Reset forces the handshake outputs low even while the CPU still requests.
        if (RESET) begin
            busy      = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        readdata = w_rd_hit ? w_word : r_readdata;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= StIdle;
            r_valid    <= '0;
            r_dirty    <= '0;
            r_readdata <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_rd_hit) r_readdata <= w_word;
            if (w_wr_hit) r_dirty[w_idx] <= 1'b1;
            if (r_state == StUpdate) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; validity alone qualifies them.
    always_ff @(posedge CLK) begin
        if (w_wr_hit) r_data[w_idx][w_off] <= writedata;
        if (r_state == StUpdate) begin
            r_tag[w_idx] <= w_tag;
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
                r_data[w_idx][w] <= mem_readdata[w*DATA_W +: DATA_W];
            end
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed bench for data_cache with a busy-handshake memory model and a
// line-level cache model that predicts every cycle of each access.
module tb_data_cache;
    localparam int unsigned MEM_BUSY = 5;
    localparam int unsigned LAT      = MEM_BUSY + 1;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        read = 1'b0, write = 1'b0;
    logic [7:0]  address = 8'h00, writedata = 8'h00;
    logic [7:0]  readdata;
    logic        busy, mem_read, mem_write, mem_busy;
    logic [5:0]  mem_addr;
    logic [31:0] mem_writedata, mem_readdata;

    data_cache #(
        .DATA_W(8), .ADDR_W(8), .NUM_LINES(8), .WORDS_PER_LINE(4)
    ) dut (
        .CLK(CLK), .RESET(RESET), .read(read), .write(write), .address(address),
        .writedata(writedata), .readdata(readdata), .busy(busy), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busy(mem_busy)
    );

    always #5 CLK = ~CLK;

    // Memory: busy from the first request cycle for MEM_BUSY cycles, then one ready cycle.
    logic [31:0] mem [64];
    int unsigned cnt;
    assign mem_busy     = (mem_read || mem_write) && (cnt < MEM_BUSY);
    assign mem_readdata = mem[mem_addr];
    always @(posedge CLK or posedge RESET) begin
        if (RESET) cnt <= 0;
        else if (mem_busy) cnt <= cnt + 1;
        else cnt <= 0;
    end
    always @(posedge CLK) begin
        if (mem_write && !mem_busy) mem[mem_addr] <= mem_writedata;
    end

    // Cache model.
    bit         m_valid [8];
    bit         m_dirty [8];
    logic [2:0] m_tag   [8];
    logic [7:0] m_word  [8][4];
    logic [7:0] m_rdata;

    int errors = 0;
    int checks = 0;
    logic [5:0]  obs_wb_addr, obs_al_addr;
    logic [31:0] obs_wb_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        m_rdata = 8'h00;
    endtask

    // Entered and left just after a posedge. Predicts every cycle of the access.
    task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
        logic [2:0]  idx, tg;
        logic [1:0]  off;
        bit          hit;
        int          nwb, nal, j;
        logic [31:0] line, blk;
        idx = a[4:2];
        off = a[1:0];
        tg  = a[7:5];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        read = rd; write = wr; address = a; writedata = d;
        if (!hit) begin
            nwb  = (m_valid[idx] && m_dirty[idx]) ? LAT : 0;
            nal  = LAT;
            line = {m_word[idx][3], m_word[idx][2], m_word[idx][1], m_word[idx][0]};
            // Cycle 0 is miss detection, then writeback, refill, and one update cycle.
            for (int k = 0; k < nwb + nal + 2; k++) begin
                @(negedge CLK);
                j = k - 1;
                chk("miss_busy", busy, 1);
                chk("miss_mem_write", mem_write, (j >= 0 && j < nwb));
                chk("miss_mem_read", mem_read, (j >= nwb && j < nwb + nal));
                chk("miss_readdata_hold", readdata, m_rdata);
                if (j >= 0 && j < nwb) begin
                    chk("wb_addr", mem_addr, {m_tag[idx], idx});
                    chk("wb_data", mem_writedata, line);
                    if (j == 0) begin
                        obs_wb_addr = mem_addr;
                        obs_wb_data = mem_writedata;
                    end
                end else if (j >= nwb && j < nwb + nal) begin
                    chk("al_addr", mem_addr, {tg, idx});
                    if (j == nwb) obs_al_addr = mem_addr;
                end
                @(posedge CLK);
                #1;
            end
            blk = mem[{tg, idx}];
            for (int w = 0; w < 4; w++) m_word[idx][w] = blk[w*8 +: 8];
            m_valid[idx] = 1;
            m_dirty[idx] = 0;
            m_tag[idx]   = tg;
        end
        @(negedge CLK);
        chk("hit_busy", busy, 0);
        chk("hit_mem_read", mem_read, 0);
        chk("hit_mem_write", mem_write, 0);
        if (rd && !wr) chk("hit_readdata", readdata, m_word[idx][off]);
        @(posedge CLK);
        #1;
        if (wr) begin
            m_word[idx][off] = d;
            m_dirty[idx]     = 1;
        end else if (rd) begin
            m_rdata = m_word[idx][off];
        end
        read = 0;
        write = 0;
        @(negedge CLK);
        chk("idle_busy", busy, 0);
        chk("idle_readdata_hold", readdata, m_rdata);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h01010101 * i;
        mem[6'h09] = 32'h44332211;
        mem[6'h29] = 32'h88776655;
        mem[6'h10] = 32'h0D0C0B0A;
        model_reset();

        #2;
        chk("rst_busy", busy, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_readdata", readdata, 8'h00);
        @(negedge CLK);
        RESET = 0;
        @(posedge CLK);
        #1;

        // Cold read miss, clean line.
        access(1, 0, 8'h25, 8'h00);
        chk("s1_al_addr", obs_al_addr, 6'h09);
        chk("s1_readdata", readdata, 8'h22);
        // Read hit in the same block.
        access(1, 0, 8'h24, 8'h00);
        chk("s2_readdata", readdata, 8'h11);
        // Write hit, then read it back.
        access(0, 1, 8'h27, 8'hAA);
        access(1, 0, 8'h27, 8'h00);
        chk("s3_readdata", readdata, 8'hAA);
        // Conflict miss on a dirty line.
        access(1, 0, 8'hA5, 8'h00);
        chk("s4_wb_addr", obs_wb_addr, 6'h09);
        chk("s4_wb_data", obs_wb_data, 32'hAA332211);
        chk("s4_al_addr", obs_al_addr, 6'h29);
        chk("s4_readdata", readdata, 8'h66);
        chk("s4_mem_block", mem[6'h09], 32'hAA332211);
        // Write miss on a clean line merges after refill.
        access(0, 1, 8'h40, 8'h5C);
        access(1, 0, 8'h40, 8'h00);
        chk("s5_readdata", readdata, 8'h5C);

        // Reset in the middle of a refill.
        read = 1;
        address = 8'h25;
        @(negedge CLK);
        chk("s6_detect_busy", busy, 1);
        @(negedge CLK);
        chk("s6_pre_mem_read", mem_read, 1);
        #2;
        RESET = 1;
        #1;
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_mem_read", mem_read, 0);
        chk("s6_rst_mem_write", mem_write, 0);
        chk("s6_rst_readdata", readdata, 8'h00);
        read = 0;
        @(posedge CLK);
        #1;
        RESET = 0;
        @(posedge CLK);
        #1;
        model_reset();
        access(1, 0, 8'h25, 8'h00);
        chk("s6_reread", readdata, 8'h22);
        // Dirty 0x5C was discarded by reset; memory still holds the original block.
        access(1, 0, 8'h40, 8'h00);
        chk("s6_discard", readdata, 8'h0A);
        access(1, 0, 8'h26, 8'h00);
        chk("s6_hit", readdata, 8'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
